load_scoreboard: RTL and testbench

Decode-stage interlock for loads: the producer-side complement to EX-stage operand forwarding. It tracks every destination register with a load outstanding, from issue until the memory stage returns the data. While a decoding instruction reads or rewrites such a register, it holds IF/ID and inserts a bubble into ID/EX. Memory latency is variable (cache misses), so pending state persists across an arbitrary number of cycles.

---
 rtl/load_scoreboard.sv | 101 ++++++++++
 tb/tb_load_scoreboard.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/load_scoreboard.sv
// Decode-stage load-use interlock: tracks registers with a load outstanding and stalls ID readers/rewriters.
// Optional stall-cycle perf counter enabled by defining SCOREBOARD_PERF_EN.
module load_scoreboard #(
  parameter int NREG  = 32,
  parameter int RW    = 5,
  parameter int MAXLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec_valid,
  input  logic [RW-1:0] dec_rs,
  input  logic [RW-1:0] dec_rt,
  input  logic          dec_useRt,
  input  logic          dec_isLoad,
  input  logic [RW-1:0] dec_rd,
  input  logic          hold,
  input  logic          ld_done,
  input  logic [RW-1:0] ld_rd,
  output logic          stall,
  output logic          issue,
  output logic          full,
  output logic          err,
  output logic [31:0]   stall_cycles
);

  localparam int CW = 4;

  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] done_oh, eff;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            raw_rs, raw_rt, waw, cap;
  logic            done_hit, ld_set;

  // A completing load is bypassed so its dependent can issue the same cycle.
  always_comb begin
    done_oh = '0;
    if (ld_done) done_oh[ld_rd] = 1'b1;
  end

  assign eff      = pending_q & ~done_oh;
  assign full     = (cnt_q == CW'(MAXLD));
  assign raw_rs   = (dec_rs != '0) & eff[dec_rs];
  assign raw_rt   = dec_useRt & (dec_rt != '0) & eff[dec_rt];
  assign waw      = dec_isLoad & (dec_rd != '0) & eff[dec_rd];
  assign cap      = dec_isLoad & full & ~ld_done;
  assign stall    = dec_valid & (raw_rs | raw_rt | waw | cap);
  assign issue    = dec_valid & ~stall & ~hold;
  assign ld_set   = issue & dec_isLoad & (dec_rd != '0);
  assign done_hit = ld_done & (ld_rd != '0) & pending_q[ld_rd];

  always_comb begin
    pending_d = pending_q;
    if (done_hit) pending_d[ld_rd] = 1'b0;
    // Set after clear: a same-register re-issue keeps the bit.
    if (ld_set)   pending_d[dec_rd] = 1'b1;
    pending_d[0] = 1'b0;

    cnt_d = cnt_q;
    case ({ld_set, done_hit})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    err_d = err_q | (ld_done & ~done_hit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] sc_q, sc_d;

  always_comb begin
    sc_d = sc_q;
    if (stall && (sc_q != '1)) sc_d = sc_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sc_q <= '0;
    else       sc_q <= sc_d;
  end

  assign stall_cycles = sc_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed scoreboard bench for load_scoreboard: expected per-cycle outputs are queued at drive time
// and popped for comparison once the combinational outputs settle.
module tb_load_scoreboard;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dec_valid = 0, dec_useRt = 0, dec_isLoad = 0, hold = 0, ld_done = 0;
  logic [4:0] dec_rs = 0, dec_rt = 0, dec_rd = 0, ld_rd = 0;
  logic       stall, issue, full, err;
  logic [31:0] stall_cycles;

  int ntests = 0;
  int nfail  = 0;
  int m_sc   = 0;

  typedef struct {
    string tag;
    logic  stall, issue, full, err;
    logic [31:0] sc;
  } exp_t;
  exp_t q[$];

  load_scoreboard #(.NREG(32), .RW(5), .MAXLD(4)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_useRt(dec_useRt), .dec_isLoad(dec_isLoad), .dec_rd(dec_rd), .hold(hold),
    .ld_done(ld_done), .ld_rd(ld_rd), .stall(stall), .issue(issue), .full(full),
    .err(err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    ntests++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic ld, input logic [4:0] rd, input logic h, input logic dn,
                     input logic [4:0] drd);
    dec_valid = v; dec_rs = rs; dec_rt = rt; dec_useRt = urt;
    dec_isLoad = ld; dec_rd = rd; hold = h; ld_done = dn; ld_rd = drd;
  endtask

  function automatic logic [31:0] exp_sc();
`ifdef SCOREBOARD_PERF_EN
    return 32'(m_sc);
`else
    return 32'd0;
`endif
  endfunction

  // Called just after a falling edge with inputs already driven; finishes on the next falling edge.
  task automatic cyc(input string tag, input logic es, input logic ei, input logic ef, input logic ee);
    exp_t e, o;
    e.tag = tag; e.stall = es; e.issue = ei; e.full = ef; e.err = ee; e.sc = exp_sc();
    q.push_back(e);
    #1;
    o = q.pop_front();
    chk({o.tag, ".stall"}, 32'(stall), 32'(o.stall));
    chk({o.tag, ".issue"}, 32'(issue), 32'(o.issue));
    chk({o.tag, ".full"},  32'(full),  32'(o.full));
    chk({o.tag, ".err"},   32'(err),   32'(o.err));
    chk({o.tag, ".sc"},    stall_cycles, o.sc);
    @(posedge clk);
    if (o.stall && m_sc != 32'hFFFF_FFFF) m_sc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    m_sc = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Reset state and basic issue/hold behaviour
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("rst_idle", 0, 0, 0, 0);
    drv(1, 3, 4, 1, 0, 0, 1, 0, 0); cyc("rst_hold", 0, 0, 0, 0);
    drv(1, 3, 4, 1, 0, 0, 0, 0, 0); cyc("rst_issue", 0, 1, 0, 0);

    // Load-use on rs with variable latency and zero-bubble release
    drv(1, 0, 0, 0, 1, 5, 0, 0, 0); cyc("lu_ld5", 0, 1, 0, 0);
    drv(1, 5, 0, 0, 0, 0, 0, 0, 0); cyc("lu_c1", 1, 0, 0, 0);
    drv(1, 5, 0, 0, 0, 0, 1, 0, 0); cyc("lu_c2_hold", 1, 0, 0, 0);
    drv(1, 5, 0, 0, 0, 0, 0, 1, 5); cyc("lu_c3_done", 0, 1, 0, 0);
    drv(1, 5, 0, 0, 0, 0, 0, 0, 0); cyc("lu_cleared", 0, 1, 0, 0);
    chk("lu_cnt", 32'(dut.cnt_q), 32'd0);

    // Register 0 is never tracked
    do_reset();
    drv(1, 0, 0, 0, 1, 0, 0, 0, 0); cyc("r0_ld", 0, 1, 0, 0);
    drv(1, 0, 0, 1, 0, 0, 0, 0, 0); cyc("r0_use", 0, 1, 0, 0);
    chk("r0_cnt", 32'(dut.cnt_q), 32'd0);

    // Capacity limit and same-cycle completion freeing a slot
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drv(1, 0, 0, 0, 1, 5'(i), 0, 0, 0);
      cyc($sformatf("cap_ld%0d", i), 0, 1, 0, 0);
    end
    drv(1, 0, 0, 0, 1, 6, 0, 0, 0); cyc("cap_full", 1, 0, 1, 0);
    drv(1, 0, 2, 1, 0, 0, 0, 0, 0); cyc("cap_raw_rt", 1, 0, 1, 0);
    drv(1, 0, 2, 0, 0, 0, 0, 0, 0); cyc("cap_nouse_rt", 0, 1, 1, 0);
    drv(1, 0, 0, 0, 1, 6, 0, 1, 1); cyc("cap_swap", 0, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("cap_after", 0, 0, 1, 0);
    chk("cap_cnt", 32'(dut.cnt_q), 32'd4);

    // WAW stall, then re-issue coinciding with completion: set wins
    do_reset();
    drv(1, 0, 0, 0, 1, 7, 0, 0, 0); cyc("waw_ld7", 0, 1, 0, 0);
    drv(1, 0, 0, 0, 1, 7, 0, 0, 0); cyc("waw_stall", 1, 0, 0, 0);
    drv(1, 0, 0, 0, 1, 7, 0, 1, 7); cyc("waw_swap", 0, 1, 0, 0);
    drv(1, 7, 0, 0, 0, 0, 0, 0, 0); cyc("waw_still", 1, 0, 0, 0);
    chk("waw_cnt", 32'(dut.cnt_q), 32'd1);

    // Spurious completion sets sticky err without touching count
    do_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 9); cyc("err_done9", 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc($sformatf("err_idle%0d", i), 0, 0, 0, 1);
    end
    chk("err_cnt", 32'(dut.cnt_q), 32'd0);
    do_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("err_done0", 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("err_r0", 0, 0, 0, 1);

    // Asynchronous reset mid-operation
    do_reset();
    drv(1, 0, 0, 0, 1, 3, 0, 0, 0); cyc("ar_ld3", 0, 1, 0, 0);
    drv(1, 0, 0, 0, 1, 4, 0, 0, 0); cyc("ar_ld4", 0, 1, 0, 0);
    drv(1, 3, 0, 0, 0, 0, 0, 0, 0); cyc("ar_pre", 1, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("ar_stall", 32'(stall), 32'd0);
    chk("ar_issue", 32'(issue), 32'd1);
    chk("ar_full",  32'(full),  32'd0);
    chk("ar_cnt",   32'(dut.cnt_q), 32'd0);
    chk("ar_sc",    stall_cycles, 32'd0);
    #2;
    reset = 1'b0;
    m_sc = 0;
    @(posedge clk); @(negedge clk);
    drv(1, 4, 0, 0, 0, 0, 0, 0, 0); cyc("ar_after", 0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
